// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between the core (priority) and the perceptron predictor, with starvation relief
module alu_share_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            c_valid,
  output logic            c_ready,
  input  logic            c_flush,
  input  logic [7:0]      c_ctrl,
  input  logic [XLEN-1:0] c_srcA,
  input  logic [XLEN-1:0] c_srcB,
  input  logic            p_valid,
  output logic            p_ready,
  input  logic [7:0]      p_ctrl,
  input  logic [XLEN-1:0] p_srcA,
  input  logic [XLEN-1:0] p_srcB,
  output logic [2:0]      alu_funct3,
  output logic            alu_funct7_6,
  output logic            alu_branch,
  output logic            alu_csrOp,
  output logic            alu_useF7,
  output logic            alu_useRegAdd,
  output logic [XLEN-1:0] alu_srcA,
  output logic [XLEN-1:0] alu_srcB,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_branchFlag,
  output logic            c_rsp_valid,
  output logic            p_rsp_valid,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_branch
);
  logic [7:0] starve_cnt;
  logic       force_p;
  logic [7:0] ctrl;
  // Grant decision and operand mux; an idle ALU sees ADD 0+0
  always_comb begin
    force_p = (starve_cnt == 8'(STARVE_MAX)) && p_valid;
    c_ready = c_valid && !force_p;
    p_ready = p_valid && (force_p || !c_valid);
    ctrl = c_ready ? c_ctrl : p_ready ? p_ctrl : 8'd0;
    alu_srcA = c_ready ? c_srcA : p_ready ? p_srcA : '0;
    alu_srcB = c_ready ? c_srcB : p_ready ? p_srcB : '0;
    {alu_useRegAdd, alu_useF7, alu_csrOp, alu_branch, alu_funct7_6, alu_funct3} = ctrl;
  end
  // Starvation counter and one-cycle response register
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 8'd0;
      c_rsp_valid <= 1'b0;
      p_rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_branch <= 1'b0;
    end else begin
      starve_cnt <= (p_valid && !p_ready) ? ((starve_cnt == 8'(STARVE_MAX)) ? starve_cnt : starve_cnt + 8'd1) : 8'd0;
      c_rsp_valid <= c_ready && !c_flush;
      p_rsp_valid <= p_ready;
      if (c_ready || p_ready) begin
        rsp_result <= alu_result;
        rsp_branch <= alu_branchFlag;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench for the shared-ALU arbiter with a behavioural ALU attached
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic c_valid, c_ready, c_flush, p_valid, p_ready;
  logic [7:0] c_ctrl, p_ctrl;
  logic [31:0] c_srcA, c_srcB, p_srcA, p_srcB;
  logic [2:0] alu_funct3;
  logic alu_funct7_6, alu_branch, alu_csrOp, alu_useF7, alu_useRegAdd;
  logic [31:0] alu_srcA, alu_srcB, alu_result;
  logic alu_branchFlag;
  logic c_rsp_valid, p_rsp_valid, rsp_branch;
  logic [31:0] rsp_result;

  int n_tests = 0;
  int n_fail = 0;
  bit mon_en = 0;

  typedef struct packed {
    logic c;
    logic p;
    logic br;
    logic [31:0] res;
  } rsp_t;
  rsp_t exp_q[$];

  alu_share_arbiter #(.STARVE_MAX(8), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_ready(c_ready), .c_flush(c_flush), .c_ctrl(c_ctrl), .c_srcA(c_srcA), .c_srcB(c_srcB),
    .p_valid(p_valid), .p_ready(p_ready), .p_ctrl(p_ctrl), .p_srcA(p_srcA), .p_srcB(p_srcB),
    .alu_funct3(alu_funct3), .alu_funct7_6(alu_funct7_6), .alu_branch(alu_branch), .alu_csrOp(alu_csrOp),
    .alu_useF7(alu_useF7), .alu_useRegAdd(alu_useRegAdd), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .alu_result(alu_result), .alu_branchFlag(alu_branchFlag),
    .c_rsp_valid(c_rsp_valid), .p_rsp_valid(p_rsp_valid), .rsp_result(rsp_result), .rsp_branch(rsp_branch)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {branch_flag, result}
  function automatic logic [32:0] alu_f(input logic [7:0] ctl, input logic [31:0] a, input logic [31:0] b);
    logic [2:0] f3;
    logic sub;
    f3 = ctl[2:0];
    sub = ctl[6] && ctl[3];
    if (ctl[4]) begin
      case (f3)
        3'b000: return {a == b, a - b};
        3'b001: return {a != b, a - b};
        3'b100: return {$signed(a) < $signed(b), a - b};
        3'b101: return {$signed(a) >= $signed(b), a - b};
        3'b110: return {a < b, a - b};
        3'b111: return {a >= b, a - b};
        default: return {1'b0, a - b};
      endcase
    end
    case (f3)
      3'b000: return {1'b0, sub ? a - b : a + b};
      3'b001: return {1'b0, a << b[4:0]};
      3'b010: return {1'b0, 32'($signed(a) < $signed(b))};
      3'b011: return {1'b0, 32'(a < b)};
      3'b100: return {1'b0, a ^ b};
      3'b101: return {1'b0, sub ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0]};
      3'b110: return {1'b0, a | b};
      default: return {1'b0, a & b};
    endcase
  endfunction

  assign {alu_branchFlag, alu_result} = alu_f({alu_useRegAdd, alu_useF7, alu_csrOp, alu_branch, alu_funct7_6, alu_funct3}, alu_srcA, alu_srcB);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: model grants from stimulus, check ALU drive, queue the expected response
  int m_cnt = 0;
  logic [32:0] m_last = '0;
  rsp_t e;
  logic fp, ec, ep;
  logic [7:0] gctl;
  logic [31:0] ga, gb;
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("c_rsp_valid", 32'(c_rsp_valid), 32'(e.c));
        check("p_rsp_valid", 32'(p_rsp_valid), 32'(e.p));
        check("rsp_result", rsp_result, e.res);
        check("rsp_branch", 32'(rsp_branch), 32'(e.br));
      end
      fp = (m_cnt == 8) && p_valid;
      ec = c_valid && !fp;
      ep = p_valid && (fp || !c_valid);
      check("c_ready", 32'(c_ready), 32'(ec));
      check("p_ready", 32'(p_ready), 32'(ep));
      gctl = ec ? c_ctrl : ep ? p_ctrl : 8'd0;
      ga = ec ? c_srcA : ep ? p_srcA : 32'd0;
      gb = ec ? c_srcB : ep ? p_srcB : 32'd0;
      check("alu_ctrl", 32'({alu_useRegAdd, alu_useF7, alu_csrOp, alu_branch, alu_funct7_6, alu_funct3}), 32'(gctl));
      check("alu_srcA", alu_srcA, ga);
      check("alu_srcB", alu_srcB, gb);
      if (rst) begin
        m_cnt = 0;
        m_last = '0;
        e = '0;
      end else begin
        if (ec || ep) m_last = alu_f(gctl, ga, gb);
        e.c = ec && !c_flush;
        e.p = ep;
        e.br = m_last[32];
        e.res = m_last[31:0];
        m_cnt = (p_valid && !ep) ? ((m_cnt == 8) ? 8 : m_cnt + 1) : 0;
      end
      exp_q.push_back(e);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input logic v, input logic [7:0] ctl, input logic [31:0] a, input logic [31:0] b);
    c_valid = v; c_ctrl = ctl; c_srcA = a; c_srcB = b;
  endtask

  task automatic set_p(input logic v, input logic [7:0] ctl, input logic [31:0] a, input logic [31:0] b);
    p_valid = v; p_ctrl = ctl; p_srcA = a; p_srcB = b;
  endtask

  int first_p, second_p;

  initial begin
    rst = 1'b1;
    c_flush = 1'b0;
    set_c(0, 8'h00, 0, 0);
    set_p(0, 8'h00, 0, 0);
    tick;
    mon_en = 1;
    tick;
    rst = 1'b0;
    tick;
    // core only: 5 + 7
    set_c(1, 8'h00, 5, 7);
    tick;
    set_c(0, 8'h00, 0, 0);
    @(negedge clk);
    check("core_add_res", rsp_result, 32'd12);
    check("core_add_cv", 32'(c_rsp_valid), 32'd1);
    check("core_add_pv", 32'(p_rsp_valid), 32'd0);
    tick;
    // predictor only: SUB 3 - 10
    set_p(1, 8'h48, 3, 10);
    tick;
    set_p(0, 8'h00, 0, 0);
    @(negedge clk);
    check("pred_sub_res", rsp_result, 32'hFFFF_FFF9);
    check("pred_sub_pv", 32'(p_rsp_valid), 32'd1);
    tick;
    // branch compares on equal operands
    set_c(1, 8'h10, 32'h1234, 32'h1234);
    tick;
    set_c(1, 8'h11, 32'h1234, 32'h1234);
    @(negedge clk);
    check("beq_flag", 32'(rsp_branch), 32'd1);
    tick;
    set_c(0, 8'h00, 0, 0);
    @(negedge clk);
    check("bne_flag", 32'(rsp_branch), 32'd0);
    tick;
    // flushed op updates result but not valid
    set_c(1, 8'h00, 20, 22);
    c_flush = 1'b1;
    tick;
    c_flush = 1'b0;
    set_c(1, 8'h00, 1, 1);
    @(negedge clk);
    check("flush_cv", 32'(c_rsp_valid), 32'd0);
    check("flush_res", rsp_result, 32'd42);
    tick;
    set_c(0, 8'h00, 0, 0);
    @(negedge clk);
    check("post_flush_cv", 32'(c_rsp_valid), 32'd1);
    check("post_flush_res", rsp_result, 32'd2);
    tick;
    // sustained contention: predictor forced through every 9th cycle
    first_p = -1;
    second_p = -1;
    set_c(1, 8'h00, 32'd100, 32'd1);
    set_p(1, 8'h64, 32'h0F0F, 32'h00FF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p_ready && first_p < 0) first_p = i;
      else if (p_ready && second_p < 0) second_p = i;
      tick;
    end
    check("starve_first", 32'(first_p), 32'd8);
    check("starve_second", 32'(second_p), 32'd17);
    set_c(0, 8'h00, 0, 0);
    set_p(0, 8'h00, 0, 0);
    tick;
    // reset mid-contention with a response pending
    set_c(1, 8'h00, 32'd100, 32'd1);
    set_p(1, 8'h06, 32'h00F0, 32'h0F00);
    for (int i = 0; i < 6; i++) tick;
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_cv", 32'(c_rsp_valid), 32'd1);
    check("pre_rst_res", rsp_result, 32'd101);
    tick;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cv", 32'(c_rsp_valid), 32'd0);
    check("rst_pv", 32'(p_rsp_valid), 32'd0);
    check("rst_res", rsp_result, 32'd0);
    first_p = -1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (p_ready && first_p < 0) first_p = i;
      tick;
    end
    check("rst_starve", 32'(first_p), 32'd8);
    set_c(0, 8'h00, 0, 0);
    set_p(0, 8'h00, 0, 0);
    tick;
    tick;
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
